// File: rtl/k_dp_2deep_fifo_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module  : k_dp_2deep_fifo_ctrl_if
// Brief   : Handshake and RAM-port bundle for the 2-deep FIFO controller.
// Revision: 1.0 - initial release
// ============================================================================
interface k_dp_2deep_fifo_ctrl_if #(
    parameter int DATA_SIZE = 8
) ();
    logic                 flush;
    logic                 push_valid;
    logic                 push_ready;
    logic [DATA_SIZE-1:0] push_data;
    logic                 pop_valid;
    logic                 pop_ready;
    logic [DATA_SIZE-1:0] pop_data;
    logic [1:0]           count;
    logic                 full;
    logic                 empty;
    logic                 ram_wen;
    logic                 ram_waddr;
    logic                 ram_raddr;
    logic [DATA_SIZE-1:0] ram_d;
    logic [DATA_SIZE-1:0] ram_q;

    // Controller side
    modport master (
        input  flush, push_valid, push_data, pop_ready, ram_q,
        output push_ready, pop_valid, pop_data, count, full, empty,
               ram_wen, ram_waddr, ram_raddr, ram_d
    );

    // User logic and RAM side
    modport slave (
        output flush, push_valid, push_data, pop_ready, ram_q,
        input  push_ready, pop_valid, pop_data, count, full, empty,
               ram_wen, ram_waddr, ram_raddr, ram_d
    );
endinterface
`default_nettype wire

// File: rtl/k_dp_2deep_fifo_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : k_dp_2deep_fifo_ctrl
// Brief   : Drives a 2-entry registered-read dual-port RAM as a 2-deep FIFO.
// Revision: 1.0 - initial release
// ============================================================================
module k_dp_2deep_fifo_ctrl #(
    parameter int DATA_SIZE = 8
) (
    input  wire logic               clk,
    input  wire logic               rst_n,
    k_dp_2deep_fifo_ctrl_if.master  bus
);
    logic                 r_wptr;
    logic                 r_rptr;
    logic [1:0]           r_count;
    logic                 r_q_valid;

    logic                 w_refresh_needed;
    logic                 w_push_ready;
    logic                 w_push_fire;
    logic                 w_pop_fire;
    logic [1:0]           w_count_next;
    logic                 w_q_valid_next;
    logic [DATA_SIZE-1:0] w_ram_d;
    logic [DATA_SIZE-1:0] w_pop_data;

    // The read port must reload before it can present a head, and a write steals that cycle.
    assign w_refresh_needed = (r_count != 2'd0) & ~r_q_valid;
    assign w_push_ready     = rst_n & ~bus.flush & (r_count < 2'd2) & ~w_refresh_needed;
    assign w_push_fire      = bus.push_valid & w_push_ready;
    assign w_pop_fire       = r_q_valid & bus.pop_ready;

    assign w_count_next     = r_count + {1'b0, w_push_fire} - {1'b0, w_pop_fire};

    always_comb begin
        w_q_valid_next = 1'b0;
        if (w_push_fire) begin
            w_q_valid_next = r_q_valid & ~w_pop_fire;
        end else begin
            w_q_valid_next = (r_count - {1'b0, w_pop_fire}) != 2'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_q_valid <= 1'b0;
        end else if (bus.flush) begin
            r_wptr    <= 1'b0;
            r_rptr    <= 1'b0;
            r_count   <= 2'd0;
            r_q_valid <= 1'b0;
        end else begin
            r_wptr    <= r_wptr ^ w_push_fire;
            r_rptr    <= r_rptr ^ w_pop_fire;
            r_count   <= w_count_next;
            r_q_valid <= w_q_valid_next;
        end
    end

    assign w_ram_d       = bus.push_data;
    assign w_pop_data    = bus.ram_q;

    assign bus.push_ready = w_push_ready;
    assign bus.pop_valid  = r_q_valid;
    assign bus.pop_data   = w_pop_data;
    assign bus.count      = r_count;
    assign bus.full       = (r_count == 2'd2);
    assign bus.empty      = (r_count == 2'd0);
    assign bus.ram_wen    = w_push_fire;
    assign bus.ram_waddr  = r_wptr;
    // Read address points at the post-pop head so the next entry is ready one cycle later.
    assign bus.ram_raddr  = r_rptr ^ w_pop_fire;
    assign bus.ram_d      = w_ram_d;
endmodule
`default_nettype wire
